apb_arb: RTL and testbench
==========================

# apb_arb

Three-master APB arbiter that sits directly upstream of the slave-interface decoder `si`. It accepts transfer requests from three master ports and grants one at a time using round-robin priority. It drives the decoder-side bus (`psel_arb`, `penable_arb`, `pwrite_mi`, `paddr_mi`, `pwdata_mi`, `way_en`) through the APB SETUP/ACCESS phases, then returns `prdata_s`/`pready_s` to the granted master as a completion pulse.

## Interface
- `ADDR_W`, 16, address width (matches `paddr_mi`)
- `DATA_W`, 32, data width (matches `pwdata_mi`/`prdata_s`)
- `TIMEOUT`, 16, ACCESS-phase cycle limit; used only with the timeout feature
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_m`  in  3  per-master request; bit i = master i
- `pwrite_m`  in  3  per-master write flag
- `paddr_m`  in  3*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
- `pwdata_m`  in  3*DATA_W  packed write data
- `way_en_m`  in  9  packed 3-bit slave selects; master i at [3*i +: 3]
- `gnt_m`  out  3  one-hot grant, held from SETUP through completion
- `done_m`  out  3  one-hot completion pulse, 1 cycle
- `err_m`  out  1  completion was a timeout; valid with `done_m`
- `prdata_m`  out  DATA_W  read data, valid with `done_m`
- `psel_arb`, `penable_arb`  out  1 each  APB phase strobes to `si`
- `pwrite_mi`  out  1  latched write flag
- `paddr_mi`  out  ADDR_W  latched address
- `pwdata_mi`  out  DATA_W  latched write data
- `way_en`  out  3  latched slave select
- `prdata_s`  in  DATA_W  read data from `si`
- `pready_s`  in  1  ready from `si`

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP when `|req_m`. The winner's fields are captured into the output registers, and `gnt_m` is set.
  - SETUP → ACCESS unconditionally.
  - ACCESS → IDLE when `pready_s` is high, or on timeout.
- Strobes by state: IDLE has `psel_arb`=0, `penable_arb`=0. SETUP has `psel_arb`=1, `penable_arb`=0. ACCESS has both =1.
- Round-robin: the search starts at (last_granted+1) mod 3. `last_granted` updates on each IDLE→SETUP and resets to 2, so master 0 has first priority.
- Captured `pwrite_mi`/`paddr_mi`/`pwdata_mi`/`way_en` hold stable from SETUP until the next grant. Master inputs may change freely after the grant.
- Completion cycle (ACCESS with `pready_s`=1):
  - `done_m` = `gnt_m` (combinational).
  - `prdata_m` = `prdata_s` on reads, 0 on writes.
  - `err_m`=0.
- `gnt_m` clears on entry to IDLE.
- Masters must drop `req_m` in the cycle after `done_m`. A request still high in IDLE is treated as a new transfer.
- `way_en`=3'b000 is passed through unchanged; `si` then returns no `pready_s`, and only the timeout feature recovers.

## Timing
- Reset value of every registered output is 0: strobes, `gnt_m`, `paddr_mi`, `pwdata_mi`, `pwrite_mi`, `way_en`. FSM goes to IDLE, `last_granted`=2.
- Reset asserted mid-transfer: IDLE on the next edge. The transfer is abandoned with no `done_m`.
- Request seen in IDLE at edge N:
  - SETUP from N+1.
  - ACCESS from N+2.
  - Earliest `done_m` is in cycle N+2 if `pready_s` is already high.
- Minimum transfer is 3 cycles (IDLE, SETUP, ACCESS). At least one IDLE cycle separates transfers (`psel_arb` low).
- Wait states are unlimited without the timeout feature.
- `pready_s` is ignored outside ACCESS.
- Simultaneous requests are resolved by the rotating priority in a single cycle.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on SETUP and counts ACCESS cycles.
  - When the count reaches TIMEOUT with `pready_s` still low, the FSM completes: `done_m` pulses, `err_m`=1, `prdata_m`=0, next state is IDLE.
  - If `pready_s` is high in that same cycle, it wins and the completion is normal.
- `APB_ARB_TIMEOUT_EN` undefined: no counter, `err_m` tied 0, and ACCESS waits indefinitely.

## Structure
- Package `apb_pkg` holds the FSM state enum (IDLE/SETUP/ACCESS), the default ADDR_W/DATA_W constants, and the 3-master count. `si` reuses it.
- One sub-module: `rr_pick3`, a combinational 3-way round-robin selector (inputs `req`, `last`; outputs one-hot grant, index). The FSM, capture registers and timeout counter stay in `apb_arb`.

## Test plan
- **Single write:** `req_m`=001, `paddr_m0`=0x0010, `pwdata_m0`=0xA5A5_0001, `way_en_m0`=001, `pready_s` returned after 2 wait states → SETUP then 3 ACCESS cycles, `done_m`=001, `err_m`=0, and outputs hold 0x0010/0xA5A5_0001 throughout.
- **Round-robin under contention:** `req_m`=111 held, each master dropping after its `done_m` and re-raising → grant order 0, 1, 2, 0, with one IDLE cycle between transfers.
- **Read data return:** master 1 reads, `prdata_s`=0x0000_0002 with `pready_s` in the first ACCESS cycle → `done_m`=010, `prdata_m`=0x2, transfer takes 3 cycles total.
- **Reset mid-ACCESS:** `rst` pulsed during a wait state → next edge all outputs 0, no `done_m`; a new request is then granted to master 0.
- **Timeout (macro defined, TIMEOUT=16):** `way_en_m0`=000, `pready_s` never asserted → `done_m`=001 and `err_m`=1 after 16 ACCESS cycles, `prdata_m`=0. With the macro undefined, the same stimulus keeps `psel_arb`/`penable_arb` high for 100 cycles.
- **Input change after grant:** master 0 changes `paddr_m0` during SETUP → `paddr_mi` is unchanged until completion.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB arbiter and the downstream si decoder.
// Holds the bus FSM state encoding, default widths, master count and a round-robin helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;
    localparam int APB_NUM_M  = 3;

    // Next master index in the 0 -> 1 -> 2 -> 0 ring; out-of-range input restarts at 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        rr_next = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/apb_arb_if.sv
// Bundle of master-side request/grant signals and si-side APB signals around apb_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface apb_arb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic [APB_NUM_M-1:0]        req_m;
    logic [APB_NUM_M-1:0]        pwrite_m;
    logic [APB_NUM_M*ADDR_W-1:0] paddr_m;
    logic [APB_NUM_M*DATA_W-1:0] pwdata_m;
    logic [APB_NUM_M*3-1:0]      way_en_m;
    logic [APB_NUM_M-1:0]        gnt_m;
    logic [APB_NUM_M-1:0]        done_m;
    logic                        err_m;
    logic [DATA_W-1:0]           prdata_m;

    logic                        psel_arb;
    logic                        penable_arb;
    logic                        pwrite_mi;
    logic [ADDR_W-1:0]           paddr_mi;
    logic [DATA_W-1:0]           pwdata_mi;
    logic [2:0]                  way_en;
    logic [DATA_W-1:0]           prdata_s;
    logic                        pready_s;

    modport slave (
        input  req_m, pwrite_m, paddr_m, pwdata_m, way_en_m, prdata_s, pready_s,
        output gnt_m, done_m, err_m, prdata_m,
        output psel_arb, penable_arb, pwrite_mi, paddr_mi, pwdata_mi, way_en
    );

    modport master (
        output req_m, pwrite_m, paddr_m, pwdata_m, way_en_m, prdata_s, pready_s,
        input  gnt_m, done_m, err_m, prdata_m,
        input  psel_arb, penable_arb, pwrite_mi, paddr_mi, pwdata_mi, way_en
    );

endinterface

// File: rtl/apb_arb_rr_pick3.sv
// Combinational 3-way round-robin selector: searches from last+1 and returns
// a one-hot grant plus the winner index (grant is zero when nothing requests).
module rr_pick3
    import apb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt,
    output logic [1:0] idx
);

    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;

    always_comb begin
        p0  = rr_next(last);
        p1  = rr_next(p0);
        p2  = rr_next(p1);
        idx = p0;
        gnt = '0;
        if (req[p0]) begin
            idx = p0;
        end else if (req[p1]) begin
            idx = p1;
        end else if (req[p2]) begin
            idx = p2;
        end
        if (|req) begin
            gnt = 3'b001 << idx;
        end
    end

endmodule

// File: rtl/apb_arb.sv
// Three-master round-robin APB arbiter driving the si decoder through SETUP/ACCESS.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arb
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input logic      clk,
    input logic      rst,
    apb_arb_if.slave bus
);

    apb_state_e          state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [2:0]          gnt_q, gnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [2:0]          way_q, way_d;

    logic [2:0]          pick_gnt;
    logic [1:0]          pick_idx;
    logic                sel_pwrite;
    logic [ADDR_W-1:0]   sel_paddr;
    logic [DATA_W-1:0]   sel_pwdata;
    logic [2:0]          sel_way;
    logic                tmo_hit;
    logic                done_fire;

    rr_pick3 u_pick (
        .req  (bus.req_m),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q equals the 1-based index of the current ACCESS cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == ACCESS && cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT));
`else
    wire unused_timeout = (TIMEOUT > 0);
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        sel_pwrite = 1'b0;
        sel_paddr  = '0;
        sel_pwdata = '0;
        sel_way    = '0;
        for (int i = 0; i < APB_NUM_M; i++) begin
            if (pick_gnt[i]) begin
                sel_pwrite = bus.pwrite_m[i];
                sel_paddr  = bus.paddr_m[i*ADDR_W +: ADDR_W];
                sel_pwdata = bus.pwdata_m[i*DATA_W +: DATA_W];
                sel_way    = bus.way_en_m[3*i +: 3];
            end
        end
    end

    assign done_fire = (state_q == ACCESS) && (bus.pready_s || tmo_hit);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        way_d     = way_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_m) begin
                    state_d   = SETUP;
                    last_d    = pick_idx;
                    gnt_d     = pick_gnt;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = sel_pwrite;
                    paddr_d   = sel_paddr;
                    pwdata_d  = sel_pwdata;
                    way_d     = sel_way;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (done_fire) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 2'd2;
            gnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            way_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            way_q     <= way_d;
        end
    end

    assign bus.gnt_m       = gnt_q;
    assign bus.psel_arb    = psel_q;
    assign bus.penable_arb = penable_q;
    assign bus.pwrite_mi   = pwrite_q;
    assign bus.paddr_mi    = paddr_q;
    assign bus.pwdata_mi   = pwdata_q;
    assign bus.way_en      = way_q;
    assign bus.done_m      = done_fire ? gnt_q : '0;
    // A completion without pready_s can only be the timeout.
    assign bus.err_m       = done_fire && !bus.pready_s;
    assign bus.prdata_m    = (done_fire && bus.pready_s && !pwrite_q) ? bus.prdata_s : '0;

endmodule

// File: tb/tb_apb_arb.sv
// Self-checking bench for apb_arb: directed scenarios plus randomized transfers
// checked against a rotating-priority reference model.
module tb_apb_arb;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   model_last;

    logic [15:0] addr  [3];
    logic [31:0] wdata [3];
    logic        wr    [3];
    logic [2:0]  way   [3];

    logic [2:0]  obs_gnt;
    logic        obs_setup_ok;
    logic        obs_hold_ok;
    logic        obs_idle_ok;
    logic [15:0] obs_addr;
    logic [31:0] obs_wdata;
    logic        obs_wr;
    logic [2:0]  obs_way;
    logic [2:0]  obs_done;
    logic        obs_err;
    logic [31:0] obs_prdata;

    apb_arb_if bus ();

    apb_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arbitration: first requesting master scanning from last+1 around the ring.
    function automatic int rr_model(input logic [2:0] mask, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (mask[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < 3; i++) begin
            bus.paddr_m[i*16 +: 16]  = addr[i];
            bus.pwdata_m[i*32 +: 32] = wdata[i];
            bus.pwrite_m[i]          = wr[i];
            bus.way_en_m[3*i +: 3]   = way[i];
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 16'($urandom);
            wdata[i] = $urandom;
            wr[i]    = 1'($urandom_range(0, 1));
            way[i]   = 3'($urandom_range(1, 7));
        end
    endtask

    // Runs one transfer starting in an IDLE cycle and records what the DUT showed.
    task automatic xfer(input logic [2:0] mask, input int waits, input logic [31:0] rdata);
        bus.req_m    = mask;
        bus.pready_s = 1'b0;
        drive_fields();
        @(posedge clk); #1;
        obs_gnt      = bus.gnt_m;
        obs_setup_ok = bus.psel_arb && !bus.penable_arb && (bus.done_m == 3'b000);
        obs_addr     = bus.paddr_mi;
        obs_wdata    = bus.pwdata_mi;
        obs_wr       = bus.pwrite_mi;
        obs_way      = bus.way_en;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = addr[i] + 16'd1 + 16'($urandom_range(0, 1000));
            wdata[i] = wdata[i] + 32'd1 + $urandom_range(0, 1000);
            wr[i]    = ~wr[i];
            way[i]   = ~way[i];
        end
        drive_fields();
        obs_hold_ok = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < waits; i++) begin
            bus.prdata_s = $urandom;
            #1;
            if (!(bus.psel_arb && bus.penable_arb) || bus.done_m != 3'b000 ||
                bus.gnt_m != obs_gnt || bus.paddr_mi != obs_addr ||
                bus.pwdata_mi != obs_wdata || bus.way_en != obs_way)
                obs_hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        bus.pready_s = 1'b1;
        bus.prdata_s = rdata;
        #1;
        if (!(bus.psel_arb && bus.penable_arb) || bus.paddr_mi != obs_addr ||
            bus.pwdata_mi != obs_wdata || bus.way_en != obs_way)
            obs_hold_ok = 1'b0;
        obs_done   = bus.done_m;
        obs_err    = bus.err_m;
        obs_prdata = bus.prdata_m;
        @(posedge clk); #1;
        bus.pready_s = 1'b0;
        bus.req_m    = 3'b000;
        #1;
        obs_idle_ok = !bus.psel_arb && !bus.penable_arb && (bus.gnt_m == 3'b000) &&
                      (bus.done_m == 3'b000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_m = 3'b000;
        bus.pready_s = 1'b0;
        bus.prdata_s = 32'h0;
        rand_fields();
        drive_fields();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.psel_arb, bus.penable_arb, bus.gnt_m, bus.done_m, bus.err_m} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {bus.psel_arb, bus.penable_arb, bus.gnt_m, bus.done_m, bus.err_m});
        end
        n_cmp++;
        if ({bus.paddr_mi, bus.pwdata_mi, bus.pwrite_mi, bus.way_en} !== 52'b0) begin
            n_bad++;
            $display("FAIL reset_data: got %h/%h/%b/%b want 0", bus.paddr_mi,
                     bus.pwdata_mi, bus.pwrite_mi, bus.way_en);
        end
        rst = 1'b0;
        model_last = 2;
    endtask

    task automatic test_single_write();
        rand_fields();
        addr[0] = 16'h0010; wdata[0] = 32'hA5A5_0001; wr[0] = 1'b1; way[0] = 3'b001;
        xfer(3'b001, 2, 32'hDEAD_BEEF);
        model_last = 0;
        n_cmp++;
        if (obs_gnt !== 3'b001) begin
            n_bad++; $display("FAIL sw_gnt: got %b want 001", obs_gnt);
        end
        n_cmp++;
        if ({obs_addr, obs_wdata, obs_wr, obs_way} !== {16'h0010, 32'hA5A5_0001, 1'b1, 3'b001}) begin
            n_bad++;
            $display("FAIL sw_capture: got %h/%h/%b/%b want 0010/a5a50001/1/001",
                     obs_addr, obs_wdata, obs_wr, obs_way);
        end
        n_cmp++;
        if ({obs_setup_ok, obs_hold_ok, obs_idle_ok} !== 3'b111) begin
            n_bad++;
            $display("FAIL sw_phases: got setup/hold/idle %b want 111",
                     {obs_setup_ok, obs_hold_ok, obs_idle_ok});
        end
        n_cmp++;
        if ({obs_done, obs_err, obs_prdata} !== {3'b001, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL sw_done: got %b/%b/%h want 001/0/0", obs_done, obs_err, obs_prdata);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        model_last = 2;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            rand_fields();
            xfer(3'b111, $urandom_range(0, 2), $urandom);
            model_last = rr_model(3'b111, model_last);
            n_cmp++;
            if (obs_gnt !== order[t] || obs_done !== order[t] || !obs_idle_ok) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got gnt %b done %b idle %b want %b/%b/1",
                         t, obs_gnt, obs_done, obs_idle_ok, order[t], order[t]);
            end
        end
    endtask

    task automatic test_read();
        int win;
        rand_fields();
        wr[1] = 1'b0;
        win = rr_model(3'b010, model_last);
        xfer(3'b010, 0, 32'h0000_0002);
        model_last = win;
        n_cmp++;
        if ({obs_gnt, obs_done, obs_err, obs_prdata} !== {3'b010, 3'b010, 1'b0, 32'h2}) begin
            n_bad++;
            $display("FAIL rd_return: got %b/%b/%b/%h want 010/010/0/00000002",
                     obs_gnt, obs_done, obs_err, obs_prdata);
        end
        n_cmp++;
        if ({obs_setup_ok, obs_hold_ok, obs_wr} !== 3'b110) begin
            n_bad++;
            $display("FAIL rd_phases: got %b want 110", {obs_setup_ok, obs_hold_ok, obs_wr});
        end
    endtask

    task automatic test_input_change();
        int win;
        rand_fields();
        addr[0] = 16'h1234;
        win = rr_model(3'b001, model_last);
        xfer(3'b001, 3, $urandom);
        model_last = win;
        n_cmp++;
        if (obs_addr !== 16'h1234 || !obs_hold_ok || obs_done !== 3'b001) begin
            n_bad++;
            $display("FAIL in_change: got addr %h hold %b done %b want 1234/1/001",
                     obs_addr, obs_hold_ok, obs_done);
        end
    endtask

    task automatic test_random();
        logic [2:0]  mask;
        logic [31:0] rdata;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_wr;
        logic [2:0]  e_way;
        logic [2:0]  e_gnt;
        int          win;
        for (int t = 0; t < 24; t++) begin
            rand_fields();
            mask  = 3'($urandom_range(1, 7));
            rdata = $urandom;
            win   = rr_model(mask, model_last);
            e_addr = addr[win]; e_wdata = wdata[win]; e_wr = wr[win]; e_way = way[win];
            e_gnt  = 3'b001 << win;
            xfer(mask, $urandom_range(0, 3), rdata);
            model_last = win;
            n_cmp++;
            if (obs_gnt !== e_gnt || obs_done !== e_gnt) begin
                n_bad++;
                $display("FAIL rnd_gnt[%0d]: mask %b got %b/%b want %b", t, mask,
                         obs_gnt, obs_done, e_gnt);
            end
            n_cmp++;
            if ({obs_addr, obs_wdata, obs_wr, obs_way} !== {e_addr, e_wdata, e_wr, e_way}) begin
                n_bad++;
                $display("FAIL rnd_capture[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", t,
                         obs_addr, obs_wdata, obs_wr, obs_way, e_addr, e_wdata, e_wr, e_way);
            end
            n_cmp++;
            if (obs_prdata !== (e_wr ? 32'h0 : rdata) || obs_err !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_prdata[%0d]: got %h err %b want %h err 0", t,
                         obs_prdata, obs_err, e_wr ? 32'h0 : rdata);
            end
            n_cmp++;
            if ({obs_setup_ok, obs_hold_ok, obs_idle_ok} !== 3'b111) begin
                n_bad++;
                $display("FAIL rnd_phases[%0d]: got %b want 111", t,
                         {obs_setup_ok, obs_hold_ok, obs_idle_ok});
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [2:0] d_before;
        rand_fields();
        drive_fields();
        bus.req_m = 3'b100;
        bus.pready_s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_before = bus.done_m;
        rst = 1'b1;
        #1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.psel_arb, bus.penable_arb, bus.gnt_m, bus.done_m, bus.err_m,
             bus.paddr_mi, bus.pwdata_mi, bus.pwrite_mi, bus.way_en, d_before} !== 64'b0) begin
            n_bad++;
            $display("FAIL rst_mid: got psel %b pen %b gnt %b done %b/%b addr %h data %h",
                     bus.psel_arb, bus.penable_arb, bus.gnt_m, d_before, bus.done_m,
                     bus.paddr_mi, bus.pwdata_mi);
        end
        rst = 1'b0;
        model_last = 2;
        rand_fields();
        xfer(3'b111, 1, $urandom);
        model_last = 0;
        n_cmp++;
        if (obs_gnt !== 3'b001 || obs_done !== 3'b001) begin
            n_bad++;
            $display("FAIL rst_regrant: got %b/%b want 001", obs_gnt, obs_done);
        end
    endtask

    task automatic test_timeout();
        int          n_acc;
        logic [2:0]  d;
        logic        e;
        logic [31:0] p;
        logic        strobes_ok;
        rand_fields();
        way[0] = 3'b000;
        drive_fields();
        bus.req_m    = 3'b001;
        bus.pready_s = 1'b0;
        bus.prdata_s = 32'hFFFF_0001;
        @(posedge clk); #1;
        bus.req_m = 3'b000;
        @(posedge clk); #1;
`ifdef APB_ARB_TIMEOUT_EN
        n_acc = 0; d = 3'b000; e = 1'b0; p = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.done_m != 3'b000) begin
                n_acc = i; d = bus.done_m; e = bus.err_m; p = bus.prdata_m;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n_acc != 16 || {d, e, p} !== {3'b001, 1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL timeout: got %0d access cycles done %b err %b prdata %h want 16/001/1/0",
                     n_acc, d, e, p);
        end
`else
        n_acc = 0; d = 3'b000; e = 1'b0; p = 32'h0;
        strobes_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!(bus.psel_arb && bus.penable_arb) || bus.done_m != 3'b000) strobes_ok = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (strobes_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL no_timeout: got strobes_ok %b want 1 over 100 cycles", strobes_ok);
        end
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 2;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_last = 2;
        rst = 1'b1;
        bus.req_m = 3'b000;
        bus.pready_s = 1'b0;
        bus.prdata_s = 32'h0;
        bus.pwrite_m = 3'b000;
        bus.paddr_m = '0;
        bus.pwdata_m = '0;
        bus.way_en_m = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_input_change();
        test_random();
        test_reset_mid_access();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
